// File: rtl/mem_arbiter_if.sv
// Signal bundle shared by the CPU port (C), the loader/debug port (L),
// the arbiter and the unified memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_done;
  logic [DW-1:0] c_rdata;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_done;
  logic [DW-1:0] l_rdata;

  logic          m_ena_R;
  logic          m_ena_W;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_W;
  logic [DW-1:0] m_data_R;
  logic          busy;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  m_data_R,
    output c_gnt, c_done, c_rdata,
    output l_gnt, l_done, l_rdata,
    output m_ena_R, m_ena_W, m_addr, m_data_W, busy
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output m_data_R,
    input  c_gnt, c_done, c_rdata,
    input  l_gnt, l_done, l_rdata,
    input  m_ena_R, m_ena_W, m_addr, m_data_W, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port fixed-priority arbiter and access sequencer for the unified memory.
// C has priority; a burst counter forces an L grant after MAX_BURST C grants.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  localparam logic [2:0] LAT_LAST  = 3'(RD_LAT);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic       OWNER_C   = 1'b0;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    latCnt_q, latCnt_d;
  logic [3:0]    burstCnt_q, burstCnt_d;
  logic          cDone_q, cDone_d;
  logic          lDone_q, lDone_d;
  logic [DW-1:0] cRdata_q, cRdata_d;
  logic [DW-1:0] lRdata_q, lRdata_d;
  logic          grantC, grantL;

  // Grants are suppressed while reset is low so nothing is accepted on the reset edge.
  always_comb begin
    grantC = 1'b0;
    grantL = 1'b0;
    if (rst && state_q == IDLE) begin
      if (bus.c_req && !(bus.l_req && burstCnt_q == BURST_MAX)) begin
        grantC = 1'b1;
      end else if (bus.l_req) begin
        grantL = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    latCnt_d   = latCnt_q;
    burstCnt_d = burstCnt_q;
    cDone_d    = 1'b0;
    lDone_d    = 1'b0;
    cRdata_d   = cRdata_q;
    lRdata_d   = lRdata_q;

    case (state_q)
      IDLE: begin
        if (grantC || grantL) begin
          owner_d  = grantL;
          we_d     = grantL ? bus.l_we    : bus.c_we;
          addr_d   = grantL ? bus.l_addr  : bus.c_addr;
          wdata_d  = grantL ? bus.l_wdata : bus.c_wdata;
          state_d  = we_d ? WR : RD;
          latCnt_d = we_d ? 3'd0 : 3'd1;
        end
        // Only C grants made while L is waiting count toward the starvation bound.
        if (grantC && bus.l_req) begin
          burstCnt_d = (burstCnt_q == BURST_MAX) ? burstCnt_q : burstCnt_q + 4'd1;
        end else if (grantC || grantL) begin
          burstCnt_d = 4'd0;
        end
      end

      WR: begin
        state_d = IDLE;
        if (owner_q == OWNER_C) cDone_d = 1'b1;
        else                    lDone_d = 1'b1;
      end

      RD: begin
        if (latCnt_q == LAT_LAST) begin
          state_d  = IDLE;
          latCnt_d = 3'd0;
          if (owner_q == OWNER_C) begin
            cDone_d  = 1'b1;
            cRdata_d = bus.m_data_R;
          end else begin
            lDone_d  = 1'b1;
            lRdata_d = bus.m_data_R;
          end
        end else begin
          latCnt_d = latCnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_C;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      latCnt_q   <= 3'd0;
      burstCnt_q <= 4'd0;
      cDone_q    <= 1'b0;
      lDone_q    <= 1'b0;
      cRdata_q   <= '0;
      lRdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      latCnt_q   <= latCnt_d;
      burstCnt_q <= burstCnt_d;
      cDone_q    <= cDone_d;
      lDone_q    <= lDone_d;
      cRdata_q   <= cRdata_d;
      lRdata_q   <= lRdata_d;
    end
  end

  // Memory address/data come straight from the captured request and hold between accesses.
  assign bus.c_gnt    = grantC;
  assign bus.l_gnt    = grantL;
  assign bus.c_done   = cDone_q;
  assign bus.l_done   = lDone_q;
  assign bus.c_rdata  = cRdata_q;
  assign bus.l_rdata  = lRdata_q;
  assign bus.m_ena_W  = (state_q == WR);
  assign bus.m_ena_R  = (state_q == RD);
  assign bus.m_addr   = addr_q;
  assign bus.m_data_W = wdata_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: dutA (RD_LAT=2, MAX_BURST=2) covers reads,
// writes, fairness and back-to-back traffic; dutB (RD_LAT=3) covers reset mid-read.
module tb_mem_arbiter;

  logic clock;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [31:0] memA [256];
  logic [31:0] memB [256];

  mem_arbiter_if #(.AW(32), .DW(32)) busA ();
  mem_arbiter_if #(.AW(32), .DW(32)) busB ();

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .MAX_BURST(2)) dutA (
    .clock (clock),
    .rst   (rst),
    .bus   (busA)
  );

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_BURST(4)) dutB (
    .clock (clock),
    .rst   (rst),
    .bus   (busB)
  );

  // Word-addressed memory models: combinational read, write at the clock edge.
  assign busA.m_data_R = memA[busA.m_addr[9:2]];
  assign busB.m_data_R = memB[busB.m_addr[9:2]];

  always @(posedge clock) begin
    if (busA.m_ena_W) memA[busA.m_addr[9:2]] <= busA.m_data_W;
    if (busB.m_ena_W) memB[busB.m_addr[9:2]] <= busB.m_data_W;
  end

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int n;
    $display("[TB] test_reset");
    busA.c_req = 1'b1; busA.l_req = 1'b1;
    busA.c_we = 1'b0;  busA.l_we = 1'b0;
    busA.c_addr = 32'h44; busA.l_addr = 32'h48;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({busA.c_gnt, busA.l_gnt} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL rst_no_gnt cycle %0d: got %b, expected 00", i, {busA.c_gnt, busA.l_gnt});
      end
    end
    vectors++;
    if ({busA.busy, busA.m_ena_R, busA.m_ena_W, busA.c_done, busA.l_done} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_ctrl_outs: got %b, expected 00000",
               {busA.busy, busA.m_ena_R, busA.m_ena_W, busA.c_done, busA.l_done});
    end
    vectors++;
    if (busA.m_addr !== 32'h0 || busA.m_data_W !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_mem_bus: got addr %h data %h, expected 0 0", busA.m_addr, busA.m_data_W);
    end
    vectors++;
    if (busA.c_rdata !== 32'h0 || busA.l_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_rdata: got c %h l %h, expected 0 0", busA.c_rdata, busA.l_rdata);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({busA.c_gnt, busA.l_gnt} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL rst_release_gnt: got %b, expected 10", {busA.c_gnt, busA.l_gnt});
    end
    step();
    busA.c_req = 1'b0; busA.l_req = 1'b0;
    n = 0;
    while (busA.c_done !== 1'b1 && n < 10) begin step(); n++; end
    vectors++;
    if (n !== 2) begin
      miscompares++;
      $display("[TB] FAIL rst_first_read_latency: got %0d, expected 2", n);
    end
    vectors++;
    if (busA.c_rdata !== 32'h1111_0044) begin
      miscompares++;
      $display("[TB] FAIL rst_first_read_data: got %h, expected 11110044", busA.c_rdata);
    end
    step();
  endtask

  task automatic test_c_read();
    $display("[TB] test_c_read");
    busA.c_req = 1'b1; busA.c_we = 1'b0; busA.c_addr = 32'h40;
    #1;
    vectors++;
    if (busA.c_gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL crd_gnt: got %b, expected 1", busA.c_gnt);
    end
    step();
    busA.c_req = 1'b0;
    #1;
    vectors++;
    if (busA.m_ena_R !== 1'b1 || busA.m_addr !== 32'h40) begin
      miscompares++;
      $display("[TB] FAIL crd_cycle1: got ena_R %b addr %h, expected 1 00000040", busA.m_ena_R, busA.m_addr);
    end
    step();
    vectors++;
    if (busA.m_ena_R !== 1'b1 || busA.c_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL crd_cycle2: got ena_R %b done %b, expected 1 0", busA.m_ena_R, busA.c_done);
    end
    step();
    vectors++;
    if (busA.c_done !== 1'b1 || busA.m_ena_R !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL crd_done: got done %b ena_R %b, expected 1 0", busA.c_done, busA.m_ena_R);
    end
    vectors++;
    if (busA.c_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL crd_data: got %h, expected deadbeef", busA.c_rdata);
    end
    vectors++;
    if (busA.l_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL crd_l_untouched: got %h, expected 00000000", busA.l_rdata);
    end
    step();
    vectors++;
    if (busA.c_done !== 1'b0 || busA.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL crd_after: got done %b busy %b, expected 0 0", busA.c_done, busA.busy);
    end
  endtask

  task automatic test_l_write_c_read();
    $display("[TB] test_l_write_c_read");
    busA.l_req = 1'b1; busA.l_we = 1'b1; busA.l_addr = 32'h10; busA.l_wdata = 32'h1234_5678;
    #1;
    vectors++;
    if ({busA.c_gnt, busA.l_gnt} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL lwr_gnt: got %b, expected 01", {busA.c_gnt, busA.l_gnt});
    end
    step();
    busA.l_req = 1'b0;
    #1;
    vectors++;
    if (busA.m_ena_W !== 1'b1 || busA.m_ena_R !== 1'b0 || busA.m_addr !== 32'h10 ||
        busA.m_data_W !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL lwr_bus: got W %b R %b addr %h data %h, expected 1 0 00000010 12345678",
               busA.m_ena_W, busA.m_ena_R, busA.m_addr, busA.m_data_W);
    end
    step();
    vectors++;
    if (busA.l_done !== 1'b1 || busA.c_done !== 1'b0 || busA.m_ena_W !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lwr_done: got l_done %b c_done %b W %b, expected 1 0 0",
               busA.l_done, busA.c_done, busA.m_ena_W);
    end
    vectors++;
    if (memA[4] !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL lwr_mem: got %h, expected 12345678", memA[4]);
    end
    busA.c_req = 1'b1; busA.c_we = 1'b0; busA.c_addr = 32'h10;
    #1;
    vectors++;
    if (busA.c_gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lwr_cgnt_on_done: got %b, expected 1", busA.c_gnt);
    end
    step();
    busA.c_req = 1'b0;
    step();
    step();
    vectors++;
    if (busA.c_done !== 1'b1 || busA.c_rdata !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL lwr_readback: got done %b data %h, expected 1 12345678", busA.c_done, busA.c_rdata);
    end
    vectors++;
    if (busA.l_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL lwr_l_rdata: got %h, expected 00000000", busA.l_rdata);
    end
    step();
  endtask

  task automatic test_fairness();
    logic [5:0] isL;
    int n;
    $display("[TB] test_fairness");
    isL = 6'b100100;
    busA.c_we = 1'b0; busA.c_addr = 32'h40;
    busA.l_we = 1'b0; busA.l_addr = 32'h44;
    busA.c_req = 1'b1; busA.l_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n = 0;
      while (!(busA.c_gnt === 1'b1 || busA.l_gnt === 1'b1) && n < 10) begin step(); n++; end
      vectors++;
      if ({busA.c_gnt, busA.l_gnt} !== (isL[k] ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("[TB] FAIL fair_order grant %0d: got %b, expected %b", k,
                 {busA.c_gnt, busA.l_gnt}, (isL[k] ? 2'b01 : 2'b10));
      end
      step();
    end
    busA.c_req = 1'b0; busA.l_req = 1'b0;
    n = 0;
    while (busA.l_done !== 1'b1 && n < 10) begin step(); n++; end
    vectors++;
    if (n !== 2 || busA.l_rdata !== 32'h1111_0044) begin
      miscompares++;
      $display("[TB] FAIL fair_l_read: got wait %0d data %h, expected 2 11110044", n, busA.l_rdata);
    end
    vectors++;
    if (busA.c_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL fair_c_read: got %h, expected deadbeef", busA.c_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    busA.l_req = 1'b0;
    busA.c_we = 1'b1; busA.c_addr = 32'h20;
    busA.c_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      busA.c_wdata = 32'h0BAD_F000 + 32'(i);
      #1;
      vectors++;
      if ({busA.c_gnt, busA.busy, busA.c_done} !== {1'b1, 1'b0, (i > 0)}) begin
        miscompares++;
        $display("[TB] FAIL b2b_grant_cycle %0d: got gnt/busy/done %b, expected %b", i,
                 {busA.c_gnt, busA.busy, busA.c_done}, {1'b1, 1'b0, (i > 0)});
      end
      step();
      vectors++;
      if ({busA.c_gnt, busA.busy, busA.m_ena_W} !== 3'b011) begin
        miscompares++;
        $display("[TB] FAIL b2b_write_cycle %0d: got gnt/busy/W %b, expected 011", i,
                 {busA.c_gnt, busA.busy, busA.m_ena_W});
      end
      if (i == 2) busA.c_req = 1'b0;
      step();
    end
    vectors++;
    if ({busA.c_gnt, busA.busy, busA.c_done} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL b2b_last_done: got gnt/busy/done %b, expected 001", {busA.c_gnt, busA.busy, busA.c_done});
    end
    vectors++;
    if (memA[8] !== 32'h0BAD_F002) begin
      miscompares++;
      $display("[TB] FAIL b2b_mem: got %h, expected 0badf002", memA[8]);
    end
    step();
    vectors++;
    if ({busA.busy, busA.c_done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL b2b_quiet: got busy/done %b, expected 00", {busA.busy, busA.c_done});
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    logic sawDone;
    $display("[TB] test_reset_mid_read");
    busB.c_we = 1'b0; busB.c_addr = 32'h38; busB.c_req = 1'b1;
    #1;
    vectors++;
    if (busB.c_gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_pre_gnt: got %b, expected 1", busB.c_gnt);
    end
    step();
    busB.c_req = 1'b0;
    n = 0;
    while (busB.c_done !== 1'b1 && n < 10) begin step(); n++; end
    vectors++;
    if (n !== 3 || busB.c_rdata !== 32'h1111_0038) begin
      miscompares++;
      $display("[TB] FAIL mid_pre_read: got wait %0d data %h, expected 3 11110038", n, busB.c_rdata);
    end
    step();
    busB.c_addr = 32'h30; busB.c_req = 1'b1;
    #1;
    step();
    busB.c_req = 1'b0;
    #1;
    vectors++;
    if (busB.m_ena_R !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_rd1: got ena_R %b, expected 1", busB.m_ena_R);
    end
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (busB.m_ena_R !== 1'b1 || busB.c_gnt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_rd2: got ena_R %b gnt %b, expected 1 0", busB.m_ena_R, busB.c_gnt);
    end
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if ({busB.m_ena_R, busB.busy, busB.c_done} !== 3'b000 || busB.c_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_after_rst: got R/busy/done %b data %h, expected 000 00000000",
               {busB.m_ena_R, busB.busy, busB.c_done}, busB.c_rdata);
    end
    vectors++;
    if (busA.c_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_rst_other_dut: got %h, expected 00000000", busA.c_rdata);
    end
    sawDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busB.c_done !== 1'b0) sawDone = 1'b1;
    end
    vectors++;
    if (sawDone !== 1'b0 || busB.c_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_no_done: got sawDone %b data %h, expected 0 00000000", sawDone, busB.c_rdata);
    end
    busB.c_addr = 32'h34; busB.c_req = 1'b1;
    #1;
    vectors++;
    if (busB.c_gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_new_gnt: got %b, expected 1", busB.c_gnt);
    end
    step();
    busB.c_req = 1'b0;
    n = 0;
    while (busB.c_done !== 1'b1 && n < 10) begin step(); n++; end
    vectors++;
    if (n !== 3 || busB.c_rdata !== 32'h5EED_0034) begin
      miscompares++;
      $display("[TB] FAIL mid_new_read: got wait %0d data %h, expected 3 5eed0034", n, busB.c_rdata);
    end
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clock = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 32'h0;
      memB[i] = 32'h0;
    end
    memA[16] = 32'hDEAD_BEEF;
    memA[17] = 32'h1111_0044;
    memB[12] = 32'hCAFE_0030;
    memB[13] = 32'h5EED_0034;
    memB[14] = 32'h1111_0038;
    busA.c_req = 1'b0; busA.c_we = 1'b0; busA.c_addr = '0; busA.c_wdata = '0;
    busA.l_req = 1'b0; busA.l_we = 1'b0; busA.l_addr = '0; busA.l_wdata = '0;
    busB.c_req = 1'b0; busB.c_we = 1'b0; busB.c_addr = '0; busB.c_wdata = '0;
    busB.l_req = 1'b0; busB.l_we = 1'b0; busB.l_addr = '0; busB.l_wdata = '0;

    test_reset();
    test_c_read();
    test_l_write_c_read();
    test_fairness();
    test_back_to_back();
    test_reset_mid_read();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
